// File: rtl/trace_unloader_pkg.sv
// ============================================================================
// Module  : trace_unloader_pkg
// Purpose : Shared definitions for the trace unloader: FSM state encodings,
//           the frame start marker and a ceiling-log2 helper for sizing.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package trace_unloader_pkg;

    // Frame start marker, first byte of every frame.
    localparam logic [7:0] HDR_BYTE = 8'hA5;

    // Unloader FSM state encodings.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_CNT_HI  = 3'd2;
    localparam logic [2:0] ST_CNT_LO  = 3'd3;
    localparam logic [2:0] ST_RD_REQ  = 3'd4;
    localparam logic [2:0] ST_RD_WAIT = 3'd5;
    localparam logic [2:0] ST_WORD    = 3'd6;
    localparam logic [2:0] ST_CHK     = 3'd7;

    // Ceiling log2; log2(1) = 0.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trace_unloader_if.sv
// ============================================================================
// Module  : trace_unloader_if
// Purpose : Byte-stream valid/ready link between the trace unloader and the
//           debug bridge.
// Signals : byte_data  - output byte
//           byte_valid - byte_data is valid
//           byte_ready - sink accepts the byte
// Modports: master (byte source), slave (byte sink)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface trace_unloader_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );
endinterface

`default_nettype wire

// File: rtl/trace_unloader_serializer.sv
// ============================================================================
// Module  : trace_word_serializer
// Purpose : Loads one FPAY-bit word and emits it as 8-bit beats, MSB byte
//           first, under a valid/ready handshake. Flags the final beat.
// Ports   : clk, reset (async, active-low)
//           load_i  - capture word_i, restart at beat 0
//           word_i  - word to serialise
//           beat_o  - current beat (top byte of the shift register)
//           valid_o - a beat is pending
//           ready_i - consumer takes the beat this cycle
//           last_o  - current beat is the last of the word
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_word_serializer
    import trace_unloader_pkg::*;
#(
    parameter int FPAY = 32
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            load_i,
    input  wire logic [FPAY-1:0] word_i,
    output logic      [7:0]      beat_o,
    output logic                 valid_o,
    input  wire logic            ready_i,
    output logic                 last_o
);

    localparam int BYTES = FPAY / 8;
    localparam int IDXW  = (BYTES > 1) ? log2(BYTES) : 1;

    logic [FPAY-1:0] shift_q;
    logic [IDXW-1:0] idx_q;
    logic            full_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            idx_q   <= '0;
            full_q  <= 1'b0;
        end else if (load_i) begin
            shift_q <= word_i;
            idx_q   <= '0;
            full_q  <= 1'b1;
        end else if (full_q && ready_i) begin
            shift_q <= shift_q << 8;
            idx_q   <= idx_q + IDXW'(1);
            if (last_o) begin
                full_q <= 1'b0;
            end
        end
    end

    assign beat_o  = shift_q[FPAY-1 -: 8];
    assign valid_o = full_q;
    assign last_o  = (idx_q == IDXW'(BYTES - 1));

endmodule

`default_nettype wire

// File: rtl/trace_unloader.sv
// ============================================================================
// Module  : trace_unloader
// Purpose : On a dump request, freezes the trace buffer and drains it into a
//           framed byte stream: HDR, CNT[15:8], CNT[7:0], CNT words MSB byte
//           first, then the XOR checksum of every byte after the header.
// Ports   : clk, reset (async, active-low)
//           dump_req_i - one-cycle dump request pulse
//           busy_o     - frame in progress
//           freeze_o   - blocks trace writes (equal to busy_o)
//           tb_count_i - valid words in the trace buffer
//           tb_rd_o    - one-cycle read strobe to the buffer
//           tb_dout_i  - buffer read data, valid one cycle after tb_rd_o
//           byte_if    - byte stream output (master)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_unloader
    import trace_unloader_pkg::*;
#(
    parameter int FPAY     = 32,
    parameter int TB_DEPTH = 512,
    parameter int CNTW     = log2(TB_DEPTH) + 1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    input  wire logic            dump_req_i,
    output logic                 busy_o,
    output logic                 freeze_o,
    input  wire logic [CNTW-1:0] tb_count_i,
    output logic                 tb_rd_o,
    input  wire logic [FPAY-1:0] tb_dout_i,
    trace_unloader_if.master     byte_if
);

    logic [2:0]  state_q, state_d;
    logic [15:0] remain_q, remain_d;   // holds N until words are sent
    logic [7:0]  chk_q, chk_d;

    logic [15:0] n_clamped;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        xfer;

    logic [7:0]  ser_beat;
    logic        ser_valid;
    logic        ser_last;
    logic        ser_load;

    trace_word_serializer #(
        .FPAY (FPAY)
    ) u_ser (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ser_load),
        .word_i  (tb_dout_i),
        .beat_o  (ser_beat),
        .valid_o (ser_valid),
        .ready_i (byte_if.byte_ready && (state_q == ST_WORD)),
        .last_o  (ser_last)
    );

    always_comb begin
        if (int'(tb_count_i) > TB_DEPTH) begin
            n_clamped = 16'(TB_DEPTH);
        end else begin
            n_clamped = 16'(tb_count_i);
        end
    end

    // Output byte is a pure function of state, so it stays stable through
    // a stall and drops immediately on an asynchronous reset.
    always_comb begin
        out_data  = 8'h00;
        out_valid = 1'b0;
        case (state_q)
            ST_HDR:    begin out_valid = 1'b1;      out_data = HDR_BYTE;        end
            ST_CNT_HI: begin out_valid = 1'b1;      out_data = remain_q[15:8];  end
            ST_CNT_LO: begin out_valid = 1'b1;      out_data = remain_q[7:0];   end
            ST_WORD:   begin out_valid = ser_valid; out_data = ser_beat;        end
            ST_CHK:    begin out_valid = 1'b1;      out_data = chk_q;           end
            default:   begin out_valid = 1'b0;      out_data = 8'h00;           end
        endcase
    end

    assign xfer = out_valid && byte_if.byte_ready;

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        chk_d    = chk_q;
        ser_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dump_req_i) begin
                    remain_d = n_clamped;
                    chk_d    = 8'h00;
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                if (xfer) state_d = ST_CNT_HI;
            end
            ST_CNT_HI: begin
                if (xfer) begin
                    chk_d   = chk_q ^ out_data;
                    state_d = ST_CNT_LO;
                end
            end
            ST_CNT_LO: begin
                if (xfer) begin
                    chk_d   = chk_q ^ out_data;
                    state_d = (remain_q == 16'd0) ? ST_CHK : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                ser_load = 1'b1;
                state_d  = ST_WORD;
            end
            ST_WORD: begin
                if (xfer) begin
                    chk_d = chk_q ^ out_data;
                    if (ser_last) begin
                        remain_d = remain_q - 16'd1;
                        state_d  = (remain_q == 16'd1) ? ST_CHK : ST_RD_REQ;
                    end
                end
            end
            ST_CHK: begin
                if (xfer) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            remain_q <= 16'd0;
            chk_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            chk_q    <= chk_d;
        end
    end

    assign busy_o             = (state_q != ST_IDLE);
    assign freeze_o           = busy_o;
    assign tb_rd_o            = (state_q == ST_RD_REQ);
    assign byte_if.byte_data  = out_data;
    assign byte_if.byte_valid = out_valid;

endmodule

`default_nettype wire

// File: tb/tb_trace_unloader.sv
// ============================================================================
// Module  : tb_trace_unloader
// Purpose : Self-checking bench for trace_unloader. A behavioural trace
//           buffer answers read strobes; expected frames are built from the
//           frame rules and compared with the captured byte stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trace_unloader;

    localparam int FPAY  = 32;
    localparam int DEPTH = 512;
    localparam int CNTW  = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            dump_req = 1'b0;
    logic [CNTW-1:0] tb_count = '0;
    logic            busy, freeze, tb_rd;
    logic [FPAY-1:0] tb_dout = '0;
    logic            byte_ready = 1'b1;

    trace_unloader_if u_if ();
    assign u_if.byte_ready = byte_ready;

    trace_unloader #(
        .FPAY     (FPAY),
        .TB_DEPTH (DEPTH),
        .CNTW     (CNTW)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .dump_req_i (dump_req),
        .busy_o     (busy),
        .freeze_o   (freeze),
        .tb_count_i (tb_count),
        .tb_rd_o    (tb_rd),
        .tb_dout_i  (tb_dout),
        .byte_if    (u_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural trace buffer: data appears one cycle after the strobe.
    logic [FPAY-1:0] mem [0:1023];
    int rd_cnt  = 0;
    int rd_base = 0;

    always @(posedge clk) begin
        if (tb_rd) begin
            tb_dout <= mem[(rd_cnt - rd_base) & 1023];
            rd_cnt  <= rd_cnt + 1;
        end
    end

    // Stream monitor.
    logic [7:0] got_q [$];
    int         busy_cyc    = 0;
    int         freeze_viol = 0;
    int         stall_viol  = 0;
    logic       prev_stall  = 1'b0;
    logic [7:0] prev_data   = 8'h00;

    always @(negedge clk) begin
        if (!reset) begin
            prev_stall <= 1'b0;
        end else begin
            if (busy) busy_cyc <= busy_cyc + 1;
            if (freeze !== busy) freeze_viol <= freeze_viol + 1;
            if (prev_stall && (u_if.byte_valid !== 1'b1 || u_if.byte_data !== prev_data))
                stall_viol <= stall_viol + 1;
            prev_stall <= u_if.byte_valid && !byte_ready;
            prev_data  <= u_if.byte_data;
            if (u_if.byte_valid && byte_ready) got_q.push_back(u_if.byte_data);
        end
    end

    // Downstream ready: always-on or random with occasional 10-cycle stalls.
    int ready_mode = 0;
    int stall_left = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                byte_ready = 1'b1;
            end else if (stall_left > 0) begin
                stall_left--;
                byte_ready = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                stall_left = 9;
                byte_ready = 1'b0;
            end else begin
                byte_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    endtask

    task automatic start_dump(input int cnt, input string name);
        tb_count = CNTW'(cnt);
        @(posedge clk);
        #1 dump_req = 1'b1;
        @(posedge clk);
        #1 dump_req = 1'b0;
        tb_count = CNTW'($urandom_range(0, 1023));   // must be ignored now
        check({name, "_first_valid"}, 32'(u_if.byte_valid), 32'd1);
    endtask

    task automatic run_frame(input int cnt, input int mode, input bit extra_req, input string name);
        logic [7:0] exp_q [$];
        logic [7:0] c, w_byte;
        logic [31:0] gv;
        int n, gb, bb, rb, fv, sv, cyc, mism;

        n = (cnt > DEPTH) ? DEPTH : cnt;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'((n >> 8) & 255));
        exp_q.push_back(8'(n & 255));
        c = 8'((n >> 8) & 255) ^ 8'(n & 255);
        for (int w = 0; w < n; w++) begin
            for (int b = FPAY / 8 - 1; b >= 0; b--) begin
                w_byte = 8'((mem[w] >> (8 * b)) & 32'hFF);
                exp_q.push_back(w_byte);
                c = c ^ w_byte;
            end
        end
        exp_q.push_back(c);

        ready_mode = mode;
        rd_base = rd_cnt;
        gb = got_q.size();
        bb = busy_cyc;
        rb = rd_cnt;
        fv = freeze_viol;
        sv = stall_viol;

        start_dump(cnt, name);
        cyc = 0;
        while (busy && cyc < 20000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (extra_req) dump_req = (cyc == 4);
        end
        dump_req = 1'b0;
        check({name, "_done"}, 32'(busy), 32'd0);

        check({name, "_len"}, 32'(got_q.size() - gb), 32'(exp_q.size()));
        mism = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            gv = (gb + i < got_q.size()) ? 32'(got_q[gb + i]) : 32'hxxxxxxxx;
            if (i < 8) check($sformatf("%s_byte%0d", name, i), gv, 32'(exp_q[i]));
            else if (gv !== 32'(exp_q[i])) mism++;
        end
        check({name, "_tail_mismatches"}, 32'(mism), 32'd0);
        if (got_q.size() > gb)
            check({name, "_chk"}, 32'(got_q[got_q.size() - 1]), 32'(c));
        check({name, "_rd_pulses"}, 32'(rd_cnt - rb), 32'(n));
        if (mode == 0)
            check({name, "_busy_cycles"}, 32'(busy_cyc - bb), 32'(3 + n * (2 + FPAY / 8) + 1));
        check({name, "_stall_stable"}, 32'(stall_viol - sv), 32'd0);
        check({name, "_freeze_eq_busy"}, 32'(freeze_viol - fv), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check({name, "_stays_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic reset_mid_frame();
        int rb, cyc;
        fill_random();
        ready_mode = 0;
        rd_base = rd_cnt;
        rb = rd_cnt;
        start_dump(3, "rst");
        cyc = 0;
        while (!((rd_cnt - rb) == 2 && u_if.byte_valid) && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rst_reached_word1", 32'(rd_cnt - rb), 32'd2);
        #2 reset = 1'b0;
        #1;
        check("rst_async_valid", 32'(u_if.byte_valid), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_freeze", 32'(freeze), 32'd0);
        check("rst_async_tb_rd", 32'(tb_rd), 32'd0);
        check("rst_async_data", 32'(u_if.byte_data), 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_idle_after", 32'(busy), 32'd0);
        fill_random();
        run_frame(5, 1, 1'b0, "post_rst");
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_freeze", 32'(freeze), 32'd0);
        check("reset_tb_rd", 32'(tb_rd), 32'd0);
        check("reset_valid", 32'(u_if.byte_valid), 32'd0);
        check("reset_data", 32'(u_if.byte_data), 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;

        fill_random();
        mem[0] = 32'h11223344;
        mem[1] = 32'hDEADBEEF;
        run_frame(0, 0, 1'b0, "empty");
        run_frame(2, 0, 1'b0, "two");
        run_frame(2, 1, 1'b0, "two_stall");
        run_frame(2, 0, 1'b1, "ignore_req");
        run_frame(2, 0, 1'b0, "after_ignore");

        fill_random();
        run_frame(700, 0, 1'b0, "clamp");

        for (int k = 0; k < 4; k++) begin
            fill_random();
            run_frame($urandom_range(0, 20), 1, 1'b0, $sformatf("rand%0d", k));
        end

        reset_mid_frame();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/trace_unloader.md
Name: trace_unloader

Overview:
- Read-side companion of the per-SoC trace buffer. On a host dump request it freezes trace capture and drains the buffer one word per read strobe.
- Each word is serialised into a framed byte stream with valid/ready handshake, for the JTAG/UART debug bridge.
- Sits beside the trace buffer in the MPSoC top level, on the same clock.

Parameters:
- Fpay, 32, trace word width in bits; must be a multiple of 8; BYTES = Fpay/8.
- TB_Depth, 512, trace buffer depth in words; must be ≤ 65535.
- CNTw, log2(TB_Depth)+1, width of the buffer fill-count input.
- HDR_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- dump_req  in  1  one-cycle pulse that starts a dump.
- busy  out  1  high from dump acceptance until the frame completes.
- freeze  out  1  to the trace buffer; blocks trace writes while high. Equal to busy.
- tb_count  in  CNTw  number of valid words in the buffer.
- tb_rd  out  1  one-cycle read strobe to the buffer.
- tb_dout  in  Fpay  buffer read data, valid exactly 1 cycle after tb_rd.
- byte_data  out  8  output byte.
- byte_valid  out  1  output byte valid.
- byte_ready  in  1  downstream accepts the byte.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, freeze=0, tb_rd=0, byte_valid=0, byte_data=0; internal counters and checksum = 0.
- A byte transfers when byte_valid & byte_ready are both high.
  - While byte_valid=1 and byte_ready=0, byte_data holds stable.
  - byte_valid never drops without a transfer.
- Frame format: HDR_BYTE, CNT[15:8], CNT[7:0], then CNT words each sent MSB byte first, then CHK.
  - CHK = XOR of every byte after the header (both count bytes and all data bytes).
- States:
  - IDLE: dump_req=1 → latch N = min(tb_count, TB_Depth), zero-extended to 16 bits. Clear checksum, set busy. Go to HDR.
  - HDR → CNT_HI → CNT_LO: each state presents one byte and advances on transfer.
  - After CNT_LO: N=0 → CHK; otherwise → RD_REQ.
  - RD_REQ: assert tb_rd for exactly 1 cycle, then go to RD_WAIT.
  - RD_WAIT: capture tb_dout into the shift register, byte_idx=0, go to WORD.
  - WORD: present shift register bits [Fpay-1:Fpay-8]. On transfer, shift left 8 and increment byte_idx.
    - After byte BYTES-1, decrement the remaining count.
    - Remaining count > 0 → RD_REQ; = 0 → CHK.
  - CHK: present the checksum byte. On transfer → IDLE; busy and freeze drop in the same cycle as the transfer edge.
- Latency:
  - dump_req to first byte_valid: 1 cycle.
  - Last data-byte transfer to next tb_rd: 1 cycle.
  - Minimum frame length with byte_ready held at 1: 3 + 4N + 1 bytes; throughput is bounded by 2 idle cycles per word.
- Boundary conditions:
  - dump_req while busy=1 is ignored; there is no queueing.
  - tb_count > TB_Depth is clamped to TB_Depth.
  - tb_count is sampled only at acceptance; later changes are ignored.
  - tb_rd is never asserted when the remaining count = 0, so the buffer is never over-read.
  - Reset asserted mid-frame aborts immediately to IDLE with all outputs at reset values. The host detects the truncated frame from the missing CHK byte.
  - byte_ready held at 0 indefinitely stalls the FSM with no loss and no extra tb_rd.

Decomposition:
- Shared package holds:
  - the FSM state enum {IDLE, HDR, CNT_HI, CNT_LO, RD_REQ, RD_WAIT, WORD, CHK};
  - the HDR_BYTE constant;
  - the log2 function.
- One sub-module, trace_word_serializer: load Fpay bits, emit 8-bit MSB-first beats with valid/ready, and flag the last beat. The top-level FSM sequences the header, count and checksum around it.

Test Plan:
- tb_count=0, dump_req, byte_ready=1 → bytes A5,00,00,00; no tb_rd pulse; busy is high for exactly 4 transfer cycles.
- tb_count=2, buffer words 0x11223344, 0xDEADBEEF → bytes A5,00,02,11,22,33,44,DE,AD,BE,EF,CHK=0x02^0x11^0x22^0x33^0x44^0xDE^0xAD^0xBE^0xEF; exactly 2 tb_rd pulses.
- Same as the previous case, but byte_ready toggles randomly (including 10-cycle 0-stalls) → identical byte sequence; byte_data stable during every stall; exactly 2 tb_rd pulses.
- tb_count=700 with TB_Depth=512 → count bytes 02,00; exactly 512 tb_rd pulses; CHK correct.
- Second dump_req issued while busy, on the 5th cycle → ignored; a single frame only; after CHK, a new dump_req starts a new frame.
- reset=0 asserted during the WORD state of word 1 → byte_valid, busy, freeze and tb_rd drop asynchronously; after release, state is IDLE and a fresh dump produces a correct full frame.
